// File: rtl/sram_sync_ft_x18_pkg.sv
// Shared definitions for the 1M x 18 flow-through burst SRAM model.
//   ADDR_W_DEF / DATA_W_DEF : default address and data widths
//   LANE_W                  : width of one byte lane (9 bits, parity included)
//   burst_order_e           : MODE pin encoding for the burst sequence
package sram_sync_ft_x18_pkg;

  localparam int unsigned ADDR_W_DEF = 20;
  localparam int unsigned DATA_W_DEF = 18;
  localparam int unsigned LANE_W     = 9;

  typedef enum logic {
    LINEAR      = 1'b0,
    INTERLEAVED = 1'b1
  } burst_order_e;

endpackage

// File: rtl/sram_burst_counter.sv
// Burst address low-bit generator.
//   base_lo : low two bits of the burst base address
//   cnt     : beat count within the burst (0..3)
//   mode    : burst order, 0 = linear, 1 = interleaved
//   addr_lo : low two bits of the current burst address
module sram_burst_counter
  import sram_sync_ft_x18_pkg::*;
(
  input  logic [1:0] base_lo,
  input  logic [1:0] cnt,
  input  logic       mode,
  output logic [1:0] addr_lo
);

  always_comb begin
    if (burst_order_e'(mode) == INTERLEAVED) begin
      addr_lo = base_lo ^ cnt;
    end else begin
      // 2-bit add wraps modulo 4 on its own
      addr_lo = base_lo + cnt;
    end
  end

endmodule

// File: rtl/sram_sync_ft_x18.sv
// Synchronous flow-through burst SRAM, 2**ADDR_W x 18 (CY7C1383-class).
//   CLK                 : rising-edge clock; address, control and write data are registered
//   RST                 : async active-high reset of control state (array is kept)
//   ZZ                  : sleep; edges ignored, DQ released
//   MODE                : burst order, 0 = linear, 1 = interleaved
//   ADDR                : word address
//   GW_N, BWE_N,
//   BWb_N, BWa_N        : global / byte write controls (lane b = DQ[17:9], lane a = DQ[8:0])
//   CE1_N, CE2, CE3_N   : chip enables
//   ADSP_N, ADSC_N      : processor / controller address strobes
//   ADV_N               : burst advance
//   OE_N                : asynchronous output enable
//   DQ                  : bidirectional data, driven straight from the array on reads
module sram_sync_ft_x18
  import sram_sync_ft_x18_pkg::*;
#(
  parameter int unsigned ADDR_W = ADDR_W_DEF,
  parameter int unsigned DATA_W = DATA_W_DEF
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              ZZ,
  input  logic              MODE,
  input  logic [ADDR_W-1:0] ADDR,
  input  logic              GW_N,
  input  logic              BWE_N,
  input  logic              BWb_N,
  input  logic              BWa_N,
  input  logic              CE1_N,
  input  logic              CE2,
  input  logic              CE3_N,
  input  logic              ADSP_N,
  input  logic              ADSC_N,
  input  logic              ADV_N,
  input  logic              OE_N,
  inout  wire  [DATA_W-1:0] DQ
);

  localparam int unsigned Depth = 2 ** ADDR_W;

  logic [DATA_W-1:0] mem [Depth];

  logic [ADDR_W-1:0] base_q;
  logic [1:0]        cnt_q;
  logic              sel_q;
  logic              rd_q;

  logic              enabled;
  logic              wr_a;
  logic              wr_b;
  logic              write;
  logic              p_load;
  logic              c_load;
  logic              cont;
  logic [1:0]        cnt_adv;
  logic [1:0]        rd_lo;
  logic [1:0]        wr_lo;
  logic [ADDR_W-1:0] rd_addr;
  logic [ADDR_W-1:0] wr_addr;
  logic              wr_en;
  logic              dq_oe;

  // Read address follows the registered burst state; the continue-write address
  // uses the count after this edge's advance.
  sram_burst_counter u_rd_ctr (
    .base_lo (base_q[1:0]),
    .cnt     (cnt_q),
    .mode    (MODE),
    .addr_lo (rd_lo)
  );

  sram_burst_counter u_wr_ctr (
    .base_lo (base_q[1:0]),
    .cnt     (cnt_adv),
    .mode    (MODE),
    .addr_lo (wr_lo)
  );

  always_comb begin
    enabled = !CE1_N & CE2 & !CE3_N;
    wr_a    = !GW_N | (!BWE_N & !BWa_N);
    wr_b    = !GW_N | (!BWE_N & !BWb_N);
    write   = wr_a | wr_b;
    // ADSP only takes effect with CE1_N low; it then overrides ADSC and writes.
    p_load  = !ADSP_N & !CE1_N;
    c_load  = !p_load & !ADSC_N;
    cont    = ADSP_N & ADSC_N & sel_q;
    cnt_adv = ADV_N ? cnt_q : cnt_q + 2'd1;
    rd_addr = {base_q[ADDR_W-1:2], rd_lo};
    wr_addr = c_load ? ADDR : {base_q[ADDR_W-1:2], wr_lo};
    wr_en   = !ZZ & write & ((c_load & enabled) | cont);
    dq_oe   = sel_q & rd_q & !OE_N & !ZZ;
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      base_q <= '0;
      cnt_q  <= 2'd0;
      sel_q  <= 1'b0;
      rd_q   <= 1'b0;
    end else if (!ZZ) begin
      if (p_load) begin
        if (enabled) begin
          base_q <= ADDR;
          cnt_q  <= 2'd0;
          sel_q  <= 1'b1;
          rd_q   <= 1'b1;
        end else begin
          sel_q  <= 1'b0;
        end
      end else if (c_load) begin
        if (enabled) begin
          base_q <= ADDR;
          cnt_q  <= 2'd0;
          sel_q  <= 1'b1;
          rd_q   <= !write;
        end else begin
          sel_q  <= 1'b0;
        end
      end else if (cont) begin
        cnt_q <= cnt_adv;
        rd_q  <= !write;
      end
    end
  end

  // Array has no reset so its contents survive RST.
  always_ff @(posedge CLK) begin
    if (wr_en) begin
      if (wr_a) mem[wr_addr][LANE_W-1:0]      <= DQ[LANE_W-1:0];
      if (wr_b) mem[wr_addr][DATA_W-1:LANE_W] <= DQ[DATA_W-1:LANE_W];
    end
  end

  assign DQ = dq_oe ? mem[rd_addr] : {DATA_W{1'bz}};

endmodule

// File: tb/tb_sram_sync_ft_x18.sv
module tb_sram_sync_ft_x18;

  localparam logic [17:0] HIZ = 18'h3FFFF;  // DQ is pulled up when nobody drives it
  localparam logic [19:0] RBASE = 20'hABC40;

  logic        CLK = 1'b0;
  logic        RST, ZZ, MODE;
  logic [19:0] ADDR;
  logic        GW_N, BWE_N, BWb_N, BWa_N;
  logic        CE1_N, CE2, CE3_N;
  logic        ADSP_N, ADSC_N, ADV_N, OE_N;
  wire  [17:0] DQ;
  logic [17:0] dq_drv;
  logic        dq_en;

  int n_vec = 0;
  int n_err = 0;

  // Reference model: word-addressed memory plus burst base/count/flags.
  logic [17:0] mmem [int unsigned];
  int unsigned m_base;
  int unsigned m_cnt;
  bit          m_sel;
  bit          m_rd;

  sram_sync_ft_x18 dut (
    .CLK    (CLK),
    .RST    (RST),
    .ZZ     (ZZ),
    .MODE   (MODE),
    .ADDR   (ADDR),
    .GW_N   (GW_N),
    .BWE_N  (BWE_N),
    .BWb_N  (BWb_N),
    .BWa_N  (BWa_N),
    .CE1_N  (CE1_N),
    .CE2    (CE2),
    .CE3_N  (CE3_N),
    .ADSP_N (ADSP_N),
    .ADSC_N (ADSC_N),
    .ADV_N  (ADV_N),
    .OE_N   (OE_N),
    .DQ     (DQ)
  );

  assign DQ = dq_en ? dq_drv : 18'bz;
  pullup pu_dq (DQ);

  always #5 CLK = ~CLK;

  function automatic int unsigned m_baddr();
    int unsigned lo;
    if (MODE) lo = (m_base & 32'd3) ^ m_cnt;
    else      lo = ((m_base & 32'd3) + m_cnt) % 4;
    return (m_base & ~32'd3) | lo;
  endfunction

  function automatic logic [17:0] m_exp();
    int unsigned a;
    if (m_sel && m_rd && !OE_N && !ZZ) begin
      a = m_baddr();
      if (mmem.exists(a)) return mmem[a];
      return 18'bx;
    end
    return HIZ;
  endfunction

  task automatic m_write(input int unsigned a);
    logic [17:0] v;
    if (!mmem.exists(a)) mmem[a] = 18'h0;
    v = mmem[a];
    if (!GW_N || (!BWE_N && !BWa_N)) v[8:0]  = dq_drv[8:0];
    if (!GW_N || (!BWE_N && !BWb_N)) v[17:9] = dq_drv[17:9];
    mmem[a] = v;
  endtask

  task automatic m_edge();
    bit en, wr;
    if (RST) begin
      m_base = 0; m_cnt = 0; m_sel = 0; m_rd = 0;
      return;
    end
    if (ZZ) return;
    en = !CE1_N && CE2 && !CE3_N;
    wr = !GW_N || (!BWE_N && (!BWa_N || !BWb_N));
    if (!ADSP_N && !CE1_N) begin
      if (en) begin m_base = 32'(ADDR); m_cnt = 0; m_sel = 1; m_rd = 1; end
      else m_sel = 0;
    end else if (!ADSC_N) begin
      if (en) begin
        m_base = 32'(ADDR); m_cnt = 0; m_sel = 1;
        if (wr) begin m_write(32'(ADDR)); m_rd = 0; end
        else m_rd = 1;
      end else m_sel = 0;
    end else if (ADSP_N && m_sel) begin
      if (!ADV_N) m_cnt = (m_cnt + 1) % 4;
      if (wr) begin m_write(m_baddr()); m_rd = 0; end
      else m_rd = 1;
    end
  endtask

  task automatic check(input string tag, input logic [17:0] obs, input logic [17:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    ZZ = 0; GW_N = 1; BWE_N = 1; BWb_N = 1; BWa_N = 1;
    CE1_N = 0; CE2 = 1; CE3_N = 0;
    ADSP_N = 1; ADSC_N = 1; ADV_N = 1; OE_N = 0; dq_en = 0;
  endtask

  // Inputs change only at the falling edge; DQ is checked there too.
  task automatic step();
    @(posedge CLK);
    m_edge();
    @(negedge CLK);
  endtask

  task automatic wr(input logic [19:0] a, input logic [17:0] d,
                    input logic gw, input logic bwe, input logic bwa, input logic bwb);
    ADSC_N = 0; ADDR = a; GW_N = gw; BWE_N = bwe; BWa_N = bwa; BWb_N = bwb;
    dq_drv = d; dq_en = 1; OE_N = 1;
    step();
    idle();
  endtask

  task automatic rd(input logic [19:0] a);
    ADSC_N = 0; ADDR = a;
    step();
    idle();
  endtask

  task automatic padsp(input logic [19:0] a);
    ADSP_N = 0; ADDR = a;
    step();
    idle();
  endtask

  task automatic adv();
    ADV_N = 0;
    step();
    idle();
  endtask

  function automatic logic [17:0] rnd18();
    logic [31:0] r;
    r = $urandom;
    return r[17:0];
  endfunction

  initial begin
    int op;
    idle();
    MODE = 0; ADDR = '0; dq_drv = '0; RST = 1;
    m_base = 0; m_cnt = 0; m_sel = 0; m_rd = 0;
    #2;
    check("reset_hiz", DQ, HIZ);
    step(); step();
    RST = 0;
    step();
    check("post_reset_idle", DQ, HIZ);

    // Basic write/read
    wr(20'h00005, 18'h2AAAA, 0, 1, 1, 1);
    rd(20'h00005);
    check("basic_rd", DQ, 18'h2AAAA);

    // Byte writes
    wr(20'h00007, 18'h3FFFF, 0, 1, 1, 1);
    wr(20'h00007, 18'h00000, 1, 0, 0, 1);
    rd(20'h00007);
    check("byte_a", DQ, 18'h3FE00);
    wr(20'h00007, 18'h3FFFF, 0, 1, 1, 1);
    wr(20'h00007, 18'h00000, 1, 0, 1, 0);
    rd(20'h00007);
    check("byte_b", DQ, 18'h001FF);

    // Linear burst
    for (int i = 0; i < 4; i++) wr(20'(i), 18'(32'h10 + i), 0, 1, 1, 1);
    MODE = 0;
    padsp(20'h00002); check("lin_0", DQ, 18'h00012);
    adv();            check("lin_1", DQ, 18'h00013);
    adv();            check("lin_2", DQ, 18'h00010);
    adv();            check("lin_3", DQ, 18'h00011);

    // Interleaved burst with a suspend
    MODE = 1;
    padsp(20'h00001); check("ilv_0", DQ, 18'h00011);
    adv();            check("ilv_1", DQ, 18'h00010);
    step();           check("ilv_suspend", DQ, 18'h00010);
    adv();            check("ilv_2", DQ, 18'h00013);
    adv();            check("ilv_3", DQ, 18'h00012);
    MODE = 0;

    // Deselect and output control
    rd(20'h00005);    check("pre_desel", DQ, 18'h2AAAA);
    ADSC_N = 0; CE2 = 0; step(); idle();
    check("desel_ce2", DQ, HIZ);
    ADSP_N = 0; CE1_N = 1; step(); idle();
    check("adsp_ce1_hi_desel", DQ, HIZ);
    rd(20'h00005);
    ADSP_N = 0; CE1_N = 1; step(); idle();
    check("adsp_ce1_hi_nochg", DQ, 18'h2AAAA);
    OE_N = 1; #1;
    check("oe_hiz", DQ, HIZ);
    OE_N = 0; #1;
    check("oe_back", DQ, 18'h2AAAA);
    ZZ = 1; #1;
    check("zz_hiz", DQ, HIZ);
    ADSC_N = 0; ADDR = 20'h00007; step();
    check("zz_edge_hiz", DQ, HIZ);
    ADSC_N = 1; ZZ = 0; #1;
    check("zz_resume", DQ, 18'h2AAAA);
    @(negedge CLK);

    // Reset mid-burst; reset beats a simultaneous strobe; array survives
    padsp(20'h00000); check("rst_burst_0", DQ, 18'h00010);
    adv();            check("rst_burst_1", DQ, 18'h00011);
    RST = 1; #1;
    check("rst_async", DQ, HIZ);
    ADSC_N = 0; ADDR = 20'h00005; step(); idle();
    check("rst_wins", DQ, HIZ);
    RST = 0;
    step();
    check("rst_still_desel", DQ, HIZ);
    rd(20'h00002);    check("rst_array_kept", DQ, 18'h00012);

    // Randomised traffic in a 16-word window against the model
    for (int i = 0; i < 16; i++) wr(RBASE + 20'(i), rnd18(), 0, 1, 1, 1);
    for (int n = 0; n < 400; n++) begin
      idle();
      op = int'($urandom_range(0, 9));
      case (op)
        0, 1: begin
          ADSC_N = 0; ADDR = RBASE + 20'($urandom_range(0, 15)); MODE = 1'($urandom_range(0, 1));
          GW_N = 1'($urandom_range(0, 1)); BWE_N = 1'($urandom_range(0, 1));
          BWa_N = 1'($urandom_range(0, 1)); BWb_N = 1'($urandom_range(0, 1));
        end
        2: begin
          ADSC_N = 0; ADDR = RBASE + 20'($urandom_range(0, 15)); MODE = 1'($urandom_range(0, 1));
        end
        3: begin
          // Write pins are don't-care on an ADSP load; the bench keeps DQ released.
          ADSP_N = 0; ADDR = RBASE + 20'($urandom_range(0, 15)); MODE = 1'($urandom_range(0, 1));
          GW_N = 1'($urandom_range(0, 1));
        end
        4, 5, 6, 7: begin
          ADV_N = 1'($urandom_range(0, 1));
          if ($urandom_range(0, 3) == 0) begin
            GW_N = 1'($urandom_range(0, 1)); BWE_N = 0;
            BWa_N = 1'($urandom_range(0, 1)); BWb_N = 1'($urandom_range(0, 1));
          end
        end
        8: begin
          ADSC_N = 0; CE3_N = 1;
        end
        default: begin
          if ($urandom_range(0, 1) == 0) ZZ = 1;
          else OE_N = 1;
          ADV_N = 1'($urandom_range(0, 1));
        end
      endcase
      if (op != 3 && (!GW_N || (!BWE_N && (!BWa_N || !BWb_N)))) begin
        dq_drv = rnd18(); dq_en = 1; OE_N = 1;
      end
      step();
      idle();
      #1;
      check("rand", DQ, m_exp());
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/sram_sync_ft_x18.md
Name: sram_sync_ft_x18

Overview:
Behavioural/synthesizable model of a 1M x 18 synchronous flow-through burst SRAM compatible with CY7C1383-class devices. Features:
- Address, control and write data are registered on the rising CLK edge.
- Read data flows from the array to DQ within the same cycle, with no output register.
- A 2-bit burst counter supports linear and interleaved order.
- Used as a memory model in board/system simulation and as a standalone memory block.

Parameters:
ADDR_W, 20, address width; array depth is 2**ADDR_W words.
DATA_W, 18, data width; two 9-bit byte lanes.

Ports:
CLK  input  1  rising-edge clock
RST  input  1  asynchronous active-high reset of control state (not the array)
ZZ  input  1  sleep; 1 = no operations, DQ high-Z
MODE  input  1  burst order; 0 = linear, 1 = interleaved
ADDR  input  ADDR_W  address
GW_N  input  1  global write, all bytes
BWE_N  input  1  byte-write enable
BWb_N  input  1  byte b write, DQ[17:9]
BWa_N  input  1  byte a write, DQ[8:0]
CE1_N, CE2, CE3_N  input  1 each  chip enables; enabled = !CE1_N & CE2 & !CE3_N
ADSP_N  input  1  processor address strobe
ADSC_N  input  1  controller address strobe
ADV_N  input  1  burst advance
OE_N  input  1  asynchronous output enable
DQ  inout  DATA_W  bidirectional data

Behaviour:
- RST=1 (asynchronous) clears: burst base, burst count, the selected flag and the read flag. With those clear, DQ is high-Z. The array is not cleared; unwritten words read X.
- Write decode:
  - wr_a = !GW_N | (!BWE_N & !BWa_N)
  - wr_b = !GW_N | (!BWE_N & !BWb_N)
  - write = wr_a | wr_b
- Per rising CLK edge with ZZ=0, first match wins:
  1. ADSP_N=0 & CE1_N=0:
     - If enabled: load base=ADDR, cnt=0, selected=1, read cycle. Write inputs are ignored.
     - Else: deselect (selected=0).
  2. ADSC_N=0:
     - If enabled: load base=ADDR, cnt=0, selected=1.
       - If write: store DQ into the enabled lanes at ADDR; read flag=0.
       - Otherwise: read flag=1.
     - Else: deselect.
  3. Neither strobe active and selected=1 (continue):
     - If ADV_N=0: cnt=cnt+1, wrapping modulo 4.
     - If write: store DQ lanes at the current (post-advance) burst address; read flag=0.
     - Otherwise: read flag=1.
  4. Otherwise: no state change.
- Burst address:
  - Upper bits = base[ADDR_W-1:2].
  - Low bits: linear = base[1:0]+cnt (mod 4); interleaved = base[1:0]^cnt.
  - The sequence wraps to the start after 4 beats.
- Flow-through read: DQ = mem[burst address] whenever selected=1 & read flag=1 & OE_N=0 & ZZ=0; otherwise high-Z.
  - Data is valid in the cycle following the capturing edge and is sampled at the next rising edge.
  - OE_N acts combinationally.
- Write data is sampled at the same edge as the write command. DQ is never driven during write cycles.
- ZZ=1:
  - DQ is high-Z.
  - Edges are ignored; state and array contents are retained.
  - On exit, operation resumes with the retained state.
- Simultaneous RST and a clock edge: reset wins.
- MODE is sampled combinationally at address formation. It must be held static during a burst.

Decomposition:
- Shared package: ADDR_W/DATA_W defaults, byte-lane width (9), and the burst-order enum (LINEAR=0, INTERLEAVED=1).
- One natural sub-module: sram_burst_counter (base, cnt, MODE -> 2-bit burst address).
- Array, control FSM and DQ tristate stay in the top level.

Test Plan:
- Basic write/read: ADSC_N=0, enabled, GW_N=0, ADDR=0x00005, DQ=0x2AAAA. Then ADSC_N=0 read of 0x00005 with OE_N=0 -> DQ=0x2AAAA at the next edge.
- Byte writes:
  - Preload 0x3FFFF at 0x7, then BWE_N=0, BWa_N=0, BWb_N=1, DQ=0x00000 -> readback 0x3FE00.
  - Repeat with BWb only -> 0x001FF.
- Linear burst, MODE=0: write 0x10,0x11,0x12,0x13 at ADDR 0x00..0x03. Then ADSP_N=0 at ADDR=0x02 followed by three cycles of ADV_N=0 -> reads 0x12,0x13,0x10,0x11.
- Interleaved burst, MODE=1, same data, start ADDR=0x01 -> reads 0x11,0x10,0x13,0x12. ADV_N=1 (suspend) repeats the current word.
- Deselect and output control, each -> DQ high-Z next cycle:
  - ADSC_N=0 with CE2=0.
  - ADSP_N=0 with CE1_N=1 and ADSC_N=1 (no change).
  - OE_N=1 during a read.
  - ZZ=1.
- Reset: assert RST mid-burst -> DQ high-Z immediately. A subsequent read of a previously written address returns its data (array preserved).
